// File: rtl/background_scroller_pkg.sv
// background_scroller_pkg: tile codes, window geometry and FSM states shared with the drawer.
package background_scroller_pkg;
  typedef logic [7:0] tile_t;
  localparam tile_t BDR = 8'd0;
  localparam tile_t SKY = 8'd1;
  localparam tile_t BLK = 8'd2;
  localparam tile_t GND = 8'd3;
  localparam tile_t TKN = 8'd4;
  localparam tile_t CLK = 8'd5;
  localparam int VIEW_ROWS = 12;
  localparam int VIEW_COLUMNS = 17;
  typedef tile_t [VIEW_ROWS-1:0][VIEW_COLUMNS-1:0] view_t;
  typedef enum logic [2:0] {INIT, IDLE, SHIFT, FETCH, WAIT_FRAME} state_t;
  function automatic logic [31:0] tile_addr(input logic [31:0] column, input logic [3:0] row);
    return column * VIEW_ROWS + {28'd0, row};
  endfunction
endpackage

// File: rtl/background_scroller_tile_column_fetcher.sv
// tile_column_fetcher: streams column-major ROM reads and returns row/col write strobes aligned to the 1-cycle ROM latency.
module tile_column_fetcher
  import background_scroller_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           start_column,
  input  logic [4:0]            column_count,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  wr,
  output logic [3:0]            wr_row,
  output logic [4:0]            wr_col,
  output logic                  done
);
  localparam logic [3:0] LAST_ROW = 4'(VIEW_ROWS - 1);
  logic [31:0] base;
  logic [4:0] count, col, col_next;
  logic [3:0] row, row_next;
  logic last, last_q;
  always_comb begin
    last = row == LAST_ROW && col == count - 5'd1;
    row_next = row == LAST_ROW ? 4'd0 : row + 4'd1;
    col_next = row == LAST_ROW ? col + 5'd1 : col;
  end
  assign done = wr && last_q;
  // wr/wr_row/wr_col trail the issued address by one cycle, lining up with rom_data
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      rom_en <= 1'b0;
      rom_addr <= '0;
      wr <= 1'b0;
      wr_row <= '0;
      wr_col <= '0;
      last_q <= 1'b0;
      row <= '0;
      col <= '0;
      base <= '0;
      count <= '0;
    end else begin
      wr <= rom_en;
      wr_row <= row;
      wr_col <= col;
      last_q <= rom_en && last;
      if (start) begin
        rom_en <= 1'b1;
        row <= '0;
        col <= '0;
        base <= start_column;
        count <= column_count;
        rom_addr <= ADDR_WIDTH'(tile_addr(start_column, 4'd0));
      end else if (rom_en) begin
        rom_en <= !last;
        if (!last) begin
          row <= row_next;
          col <= col_next;
          rom_addr <= ADDR_WIDTH'(tile_addr(base + 32'(col_next), row_next));
        end
      end
    end
  end
endmodule

// File: rtl/background_scroller.sv
// background_scroller: double-buffered scrolling tile window over a level ROM, committed on frame_start.
module background_scroller
  import background_scroller_pkg::*;
#(
  parameter int    LEVEL_COLUMNS  = 128,
  parameter tile_t FILL_TILE      = SKY,
  parameter int    ROM_ADDR_WIDTH = 11
) (
  input  logic                      vga_clock,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      scroll_request,
  output logic                      rom_en,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]                rom_data,
  output view_t                     background,
  output logic [31:0]               scroll_column,
  output logic                      busy,
  output logic                      at_end
);
  state_t state, state_next;
  view_t shadow;
  logic launched, first, start, wr, done, commit;
  logic [3:0] wr_row;
  logic [4:0] wr_col, dest_col;
  assign busy = state != IDLE && !reset;
  assign at_end = scroll_column + 32'(VIEW_COLUMNS) == 32'(LEVEL_COLUMNS);
  assign start = (state == INIT && !launched) || state == SHIFT;
  assign commit = state == WAIT_FRAME && frame_start;
  assign dest_col = state == INIT ? wr_col : 5'(VIEW_COLUMNS - 1);
  tile_column_fetcher #(.ADDR_WIDTH(ROM_ADDR_WIDTH)) fetcher (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .start       (start),
    .start_column(state == INIT ? 32'd0 : scroll_column + 32'(VIEW_COLUMNS)),
    .column_count(state == INIT ? 5'(VIEW_COLUMNS) : 5'd1),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .wr          (wr),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .done        (done)
  );
  always_comb begin
    state_next = state;
    case (state)
      INIT, FETCH: state_next = done ? WAIT_FRAME : state;
      IDLE:        state_next = scroll_request && !at_end ? SHIFT : IDLE;
      SHIFT:       state_next = FETCH;
      WAIT_FRAME:  state_next = frame_start ? IDLE : WAIT_FRAME;
      default:     state_next = INIT;
    endcase
  end
  // the initial load commits without advancing scroll_column
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state <= INIT;
      launched <= 1'b0;
      first <= 1'b1;
      scroll_column <= '0;
      shadow <= {(VIEW_ROWS * VIEW_COLUMNS){FILL_TILE}};
      background <= {(VIEW_ROWS * VIEW_COLUMNS){FILL_TILE}};
    end else begin
      state <= state_next;
      launched <= launched || state == INIT;
      if (state == SHIFT)
        for (int r = 0; r < VIEW_ROWS; r++) shadow[r][VIEW_COLUMNS-2:0] <= shadow[r][VIEW_COLUMNS-1:1];
      if (wr) shadow[wr_row][dest_col] <= rom_data;
      if (commit) begin
        background <= shadow;
        first <= 1'b0;
        if (!first) scroll_column <= scroll_column + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_background_scroller.sv
// tb_background_scroller: scoreboard bench; commits are checked against a ROM model as busy falls.
module tb_background_scroller;
  import background_scroller_pkg::*;
  logic vga_clock = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic scroll_request = 1'b0;
  logic rom_en, busy, at_end;
  logic [10:0] rom_addr;
  logic [7:0] rom_data = 8'd0;
  view_t background;
  logic [31:0] scroll_column;
  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 vga_clock = ~vga_clock;

  background_scroller dut (
    .vga_clock     (vga_clock),
    .reset         (reset),
    .frame_start   (frame_start),
    .scroll_request(scroll_request),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .background    (background),
    .scroll_column (scroll_column),
    .busy          (busy),
    .at_end        (at_end)
  );

  function automatic tile_t tile(int a);
    return tile_t'(a % 251);
  endfunction

  always @(posedge vga_clock) if (rom_en) rom_data <= tile(int'(rom_addr));

  function automatic view_t model(int sc);
    view_t m;
    for (int r = 0; r < VIEW_ROWS; r++)
      for (int c = 0; c < VIEW_COLUMNS; c++) m[r][c] = tile((sc + c) * VIEW_ROWS + r);
    return m;
  endfunction

  function automatic view_t filled();
    view_t m;
    for (int r = 0; r < VIEW_ROWS; r++)
      for (int c = 0; c < VIEW_COLUMNS; c++) m[r][c] = SKY;
    return m;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bg(string name, view_t exp);
    bit shown = 0;
    checks++;
    if (background !== exp) begin
      errors++;
      for (int r = 0; r < VIEW_ROWS; r++)
        for (int c = 0; c < VIEW_COLUMNS; c++)
          if (!shown && background[r][c] !== exp[r][c]) begin
            shown = 1;
            $display("FAIL %s: background[%0d][%0d] got %0d expected %0d", name, r, c, background[r][c], exp[r][c]);
          end
    end
  endtask

  task automatic tick();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic request();
    scroll_request = 1'b1;
    tick();
    scroll_request = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic monitor();
    logic prev = 1'b0;
    int e;
    forever begin
      @(negedge vga_clock);
      if (!reset && prev && !busy) begin
        check("commit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("commit_scroll_column", scroll_column, e);
          check_bg("commit_background", model(e));
          check("commit_at_end", at_end, e + VIEW_COLUMNS == 128);
        end
      end
      prev = busy;
    end
  endtask

  task automatic init_load();
    int n = 0;
    reset = 1'b1;
    repeat (2) tick();
    check("reset_busy", busy, 0);
    check("reset_at_end", at_end, 0);
    check("reset_scroll_column", scroll_column, 0);
    check("reset_rom_en", rom_en, 0);
    check("reset_rom_addr", rom_addr, 0);
    check_bg("reset_background", filled());
    reset = 1'b0;
    while (!rom_en && n < 10) begin
      tick();
      n++;
    end
    check("init_rom_en", rom_en, 1);
    check("init_first_addr", rom_addr, 0);
    repeat (220) tick();
    check("init_wait_busy", busy, 1);
    check_bg("init_before_frame", filled());
    exp_q.push_back(0);
    pulse_frame();
    wait_idle("init_commit_timeout");
  endtask

  initial begin
    fork
      monitor();
    join_none
    init_load();
    // single scroll, frame at N+20; window must not move before that edge
    request();
    repeat (18) tick();
    check_bg("scroll_held_before_frame", model(0));
    check("scroll_busy_waiting", busy, 1);
    tick();
    exp_q.push_back(1);
    pulse_frame();
    wait_idle("scroll_commit_timeout");
    // second request at N+5 is dropped
    request();
    repeat (4) tick();
    request();
    repeat (14) tick();
    exp_q.push_back(2);
    pulse_frame();
    wait_idle("double_commit_timeout");
    repeat (3) tick();
    check("double_no_second_scroll", busy, 0);
    check("double_scroll_column", scroll_column, 2);
    // frame pulses at N+3 and N+10 are ignored; the N+15 pulse commits
    request();
    repeat (2) tick();
    pulse_frame();
    repeat (6) tick();
    pulse_frame();
    repeat (4) tick();
    check("fetch_frames_ignored", busy, 1);
    exp_q.push_back(3);
    pulse_frame();
    wait_idle("n15_commit_timeout");
    // simultaneous request and frame in IDLE: request wins, no commit
    scroll_request = 1'b1;
    frame_start = 1'b1;
    tick();
    scroll_request = 1'b0;
    frame_start = 1'b0;
    check("simultaneous_accepted", busy, 1);
    repeat (15) tick();
    exp_q.push_back(4);
    pulse_frame();
    wait_idle("simultaneous_commit_timeout");
    for (int s = 5; s <= 111; s++) begin
      if (s == 111) check("at_end_before_last", at_end, 0);
      request();
      repeat (14) tick();
      exp_q.push_back(s);
      pulse_frame();
      wait_idle("sweep_commit_timeout");
    end
    check("at_end_reached", at_end, 1);
    request();
    check("at_end_request_ignored", busy, 0);
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      check("at_end_stays_idle", busy, 0);
      check("at_end_scroll_column", scroll_column, 111);
    end
    // reset mid-FETCH
    init_load();
    request();
    repeat (5) tick();
    check("midfetch_rom_en", rom_en, 1);
    reset = 1'b1;
    tick();
    check_bg("midfetch_reset_background", filled());
    check("midfetch_reset_scroll_column", scroll_column, 0);
    check("midfetch_reset_rom_en", rom_en, 0);
    init_load();
    repeat (3) tick();
    check("pending_commits", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
